rx_sync_controller: RTL and testbench
=====================================

// Module: rx_sync_controller
// PURPOSE
// Sequences the PHY RX serial front end on clk_32f. Searches the serial stream for the
// COMMA character (0xBC) and locks the byte boundary after SYNC_COUNT aligned commas.
// While locked, delivers parallel bytes plus a round-robin lane select (0..3) that drives
// the 4-lane demux. Drops lock when no COMMA is seen within MAX_GAP bytes.
// PARAMETERS
// COMMA       8'hBC  alignment/frame character; resets lane_sel, never marked valid
// IDLE        8'h7C  idle filler; never marked valid, does not advance lane_sel
// SYNC_COUNT  4      consecutive aligned COMMAs required to enter ACTIVE (>=1)
// MAX_GAP     16     bytes allowed between COMMAs in ACTIVE before loss of sync (<=255)
// PORTS
// clk_32f     in   1  bit clock, one serial bit per rising edge
// reset       in   1  asynchronous reset, active-high
// data_in     in   1  serial data, MSB first
// active      out  1  1 while in ACTIVE state
// byte_out    out  8  last aligned byte captured in ACTIVE
// byte_valid  out  1  1-cycle pulse: byte_out is a data byte (not COMMA/IDLE)
// lane_sel    out  2  destination lane for byte_out, valid with byte_valid
// BEHAVIOUR
// - reset=1 (async): state=SEARCH; sreg, bit_cnt, sync_cnt, gap_cnt, lane_sel <= 0;
//   active=0, byte_out=8'h00, byte_valid=0. All outputs registered.
// - sreg <= {sreg[6:0], data_in} every cycle; nxt = {sreg[6:0], data_in} is used for compares.
// - SEARCH: bit-by-bit compare. nxt==COMMA -> ALIGN, bit_cnt<=0, sync_cnt<=1
//   (if SYNC_COUNT==1 -> ACTIVE directly, gap_cnt<=0, lane_sel<=0).
// - bit_cnt 3-bit, increments every cycle outside SEARCH; byte boundary when bit_cnt==7.
// - ALIGN, at boundary: nxt==COMMA -> sync_cnt+1; if sync_cnt+1==SYNC_COUNT -> ACTIVE,
//   gap_cnt<=0, lane_sel<=0. nxt!=COMMA -> SEARCH, sync_cnt<=0. No outputs change in ALIGN.
// - ACTIVE, at boundary: byte_out<=nxt.
//   COMMA: lane_sel<=0, gap_cnt<=0, byte_valid=0.
//   IDLE:  gap_cnt+1, byte_valid=0, lane_sel held.
//   other: byte_valid=1 for exactly 1 cycle, lane_sel shows this byte's lane;
//          lane_sel increments (wraps 3->0) on the cycle after the pulse; gap_cnt+1.
//   Not at boundary: byte_valid=0.
// - Latency: byte_valid/byte_out update at the edge that samples the byte's 8th bit,
//   visible on the following cycle. byte_valid is max 1 pulse per 8 cycles.
// - Loss of sync: if gap_cnt would reach MAX_GAP at a boundary without COMMA -> SEARCH.
//   active=0 from the next cycle. That byte is still output with its normal
//   valid/lane rule. sync_cnt <= 0.
// - COMMA at an unaligned offset in ACTIVE is ignored (no realignment until SEARCH).
// - reset mid-byte or mid-ACTIVE: immediate return to reset values, no partial byte emitted.
// - gap_cnt saturates at MAX_GAP; lane_sel is 2-bit modular.
// TESTING
// T1 reset: assert reset during random data -> active=0, byte_valid=0, byte_out=00,
//    lane_sel=0 at the same cycle, not waiting for a clock edge.
// T2 lock: 4x 0xBC MSB-first, then 0x11,0x22,0x33,0x44,0x55 -> active rises after 4th BC.
//    byte_valid pulses 5 times, 8 cycles apart, lane_sel=0,1,2,3,0.
// T3 false lock: BC, BC, 0x00, BC... -> return to SEARCH after 0x00.
//    active stays 0 until 4 consecutive aligned BCs.
// T4 idle/comma: in ACTIVE send 0xAA,0x7C,0xBC,0xBB -> one pulse with lane 0 (AA).
//    No pulse for 7C/BC. BB is sent with lane_sel=0 because BC reset the lane.
// T5 loss: in ACTIVE send 16 non-comma bytes -> active falls 1 cycle after 16th byte.
//    16th byte still pulses valid. Re-lock then requires 4 BCs.
// T6 shift: lock, then insert one extra bit (slip), keep frame with BC every 8 bytes
//    -> loss after MAX_GAP, relock on new boundary, data correct afterwards.

Source files
------------

// File: rtl/rx_sync_controller.sv
// rx_sync_controller: COMMA-based byte alignment and lane sequencing for the serial RX path.
// Locks after SYNC_COUNT aligned commas and drops lock after MAX_GAP bytes without one.
`timescale 1ns/1ps
module rx_sync_controller #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter logic [7:0] IDLE       = 8'h7C,
    parameter int         SYNC_COUNT = 4,
    parameter int         MAX_GAP    = 16
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic       active,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [1:0] lane_sel
);
    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
    state_t     state;
    logic [7:0] sreg, nxt, gap_cnt, sync_cnt;
    logic [2:0] bit_cnt;
    logic       boundary, is_comma, is_idle, sync_done, gap_last;
    assign nxt       = {sreg[6:0], data_in};
    assign boundary  = bit_cnt == 3'd7;
    assign is_comma  = nxt == COMMA;
    assign is_idle   = nxt == IDLE;
    assign sync_done = sync_cnt + 8'd1 == 8'(SYNC_COUNT);
    // 9-bit sum keeps the MAX_GAP=255 case from wrapping
    assign gap_last  = ({1'b0, gap_cnt} + 9'd1) >= 9'(MAX_GAP);
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            sreg       <= 8'h00;
            bit_cnt    <= 3'd0;
            sync_cnt   <= 8'h00;
            gap_cnt    <= 8'h00;
            lane_sel   <= 2'd0;
            active     <= 1'b0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            sreg       <= nxt;
            byte_valid <= 1'b0;
            bit_cnt    <= (state == SEARCH) ? 3'd0 : bit_cnt + 3'd1;
            // lane advances one cycle after the pulse so lane_sel is stable with byte_valid
            if (byte_valid)
                lane_sel <= lane_sel + 2'd1;
            case (state)
                SEARCH: if (is_comma) begin
                    sync_cnt <= 8'd1;
                    if (SYNC_COUNT == 1) begin
                        state    <= ACTIVE;
                        active   <= 1'b1;
                        gap_cnt  <= 8'h00;
                        lane_sel <= 2'd0;
                    end else
                        state <= ALIGN;
                end
                ALIGN: if (boundary) begin
                    if (is_comma) begin
                        sync_cnt <= sync_cnt + 8'd1;
                        if (sync_done) begin
                            state    <= ACTIVE;
                            active   <= 1'b1;
                            gap_cnt  <= 8'h00;
                            lane_sel <= 2'd0;
                        end
                    end else begin
                        state    <= SEARCH;
                        sync_cnt <= 8'h00;
                    end
                end
                ACTIVE: if (boundary) begin
                    byte_out <= nxt;
                    if (is_comma) begin
                        lane_sel <= 2'd0;
                        gap_cnt  <= 8'h00;
                    end else begin
                        byte_valid <= !is_idle;
                        gap_cnt    <= gap_last ? 8'(MAX_GAP) : gap_cnt + 8'd1;
                        if (gap_last) begin
                            state    <= SEARCH;
                            active   <= 1'b0;
                            sync_cnt <= 8'h00;
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_sync_controller.sv
// tb_rx_sync_controller: directed bench for lock, idle/comma handling, loss of sync,
// asynchronous reset, false lock and bit slip recovery.
`timescale 1ns/1ps
module tb_rx_sync_controller;
    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic       active, byte_valid;
    logic [7:0] byte_out;
    logic [1:0] lane_sel;
    logic [7:0] bc = 8'hBC;
    logic [7:0] d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int errors = 0;
    int checks = 0;

    always #5 clk_32f = ~clk_32f;

    rx_sync_controller dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .active(active),
        .byte_out(byte_out), .byte_valid(byte_valid), .lane_sel(lane_sel)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    initial begin
        // power-up reset, observed before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_active", 8'(active), 8'd0);
        chk("rst_valid", 8'(byte_valid), 8'd0);
        chk("rst_byte", byte_out, 8'h00);
        chk("rst_lane", 8'(lane_sel), 8'd0);
        #3 reset = 1'b0;
        @(posedge clk_32f);
        #1;

        // lock on four aligned commas, then five data bytes
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            chk("lock_active", 8'(active), (k == 3) ? 8'd1 : 8'd0);
        end
        for (int i = 0; i < 5; i++) begin
            send_byte(d[i]);
            chk("data_valid", 8'(byte_valid), 8'd1);
            chk("data_byte", byte_out, d[i]);
            chk("data_lane", 8'(lane_sel), 8'(i % 4));
        end
        send_bit(bc[7]);
        chk("pulse_width", 8'(byte_valid), 8'd0);
        chk("lane_advance", 8'(lane_sel), 8'd1);
        for (int i = 6; i >= 0; i--) send_bit(bc[i]);
        chk("comma_valid", 8'(byte_valid), 8'd0);
        chk("comma_lane", 8'(lane_sel), 8'd0);
        chk("comma_byte", byte_out, 8'hBC);

        // idle and comma handling in ACTIVE
        send_byte(8'hAA);
        chk("aa_valid", 8'(byte_valid), 8'd1);
        chk("aa_lane", 8'(lane_sel), 8'd0);
        send_byte(8'h7C);
        chk("idle_valid", 8'(byte_valid), 8'd0);
        chk("idle_byte", byte_out, 8'h7C);
        chk("idle_lane", 8'(lane_sel), 8'd1);
        send_byte(8'hBC);
        chk("bc_valid", 8'(byte_valid), 8'd0);
        chk("bc_lane", 8'(lane_sel), 8'd0);
        send_byte(8'hBB);
        chk("bb_valid", 8'(byte_valid), 8'd1);
        chk("bb_byte", byte_out, 8'hBB);
        chk("bb_lane", 8'(lane_sel), 8'd0);

        // loss of sync after 16 non-comma bytes
        send_byte(8'hBC);
        for (int i = 1; i <= 16; i++) begin
            send_byte(8'(i));
            chk("gap_valid", 8'(byte_valid), 8'd1);
            chk("gap_byte", byte_out, 8'(i));
            chk("gap_lane", 8'(lane_sel), 8'((i - 1) % 4));
            chk("gap_active", 8'(active), (i < 16) ? 8'd1 : 8'd0);
        end
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            chk("relock_active", 8'(active), (k == 3) ? 8'd1 : 8'd0);
        end

        // asynchronous reset in the middle of a byte while ACTIVE
        send_byte(8'h5A);
        chk("pre_rst_lane0", 8'(lane_sel), 8'd0);
        send_byte(8'h6B);
        chk("pre_rst_valid", 8'(byte_valid), 8'd1);
        chk("pre_rst_lane1", 8'(lane_sel), 8'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("pre_rst_lane2", 8'(lane_sel), 8'd2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_active", 8'(active), 8'd0);
        chk("mid_rst_valid", 8'(byte_valid), 8'd0);
        chk("mid_rst_byte", byte_out, 8'h00);
        chk("mid_rst_lane", 8'(lane_sel), 8'd0);
        #2 reset = 1'b0;
        @(posedge clk_32f);
        #1;

        // false lock: a non-comma at an aligned boundary restarts the search
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("align_byte_held", byte_out, 8'h00);
        send_byte(8'h00);
        chk("false_active", 8'(active), 8'd0);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            chk("false_relock", 8'(active), (k == 3) ? 8'd1 : 8'd0);
        end

        // one-bit slip: misaligned commas are ignored until sync is lost
        send_bit(1'b0);
        for (int i = 7; i >= 1; i--) send_bit(bc[i]);
        chk("slip_valid", 8'(byte_valid), 8'd1);
        chk("slip_byte", byte_out, 8'h5E);
        chk("slip_lane", 8'(lane_sel), 8'd0);
        send_bit(bc[0]);
        for (int i = 0; i < 7; i++) send_byte(8'h00);
        chk("slip_active_a", 8'(active), 8'd1);
        send_byte(8'hBC);
        for (int i = 0; i < 6; i++) send_byte(8'h00);
        chk("slip_active_b", 8'(active), 8'd1);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        chk("slip_last_valid", 8'(byte_valid), 8'd1);
        chk("slip_last_lane", 8'(lane_sel), 8'd3);
        chk("slip_loss", 8'(active), 8'd0);
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            chk("slip_relock", 8'(active), (k == 3) ? 8'd1 : 8'd0);
        end
        send_byte(8'h3C);
        chk("post_slip_valid", 8'(byte_valid), 8'd1);
        chk("post_slip_byte", byte_out, 8'h3C);
        chk("post_slip_lane", 8'(lane_sel), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
